// File: rtl/io_protocol_monitor_pkg.sv
// Shared types and helpers for io_protocol_monitor: FSM states, error codes,
// and a width-generic saturating adder.
package io_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IN,
        ST_WAIT,
        ST_OUT,
        ST_ERR
    } mon_state_t;

    // Numeric value doubles as priority: the lowest code wins on a tie.
    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_OVERLAP  = 3'd1,
        ERR_NONZERO  = 3'd2,
        ERR_LATENCY  = 3'd3,
        ERR_OUT_CNT  = 3'd4,
        ERR_IN_LEN   = 3'd5,
        ERR_SPURIOUS = 3'd6
    } err_code_t;

    // Saturating add clamped to w bits (w <= 63, operands already < 2**w).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          w);
        logic [63:0] sum;
        logic [63:0] lim;
        sum = a + b;
        lim = (64'd1 << w) - 64'd1;
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/io_protocol_monitor_if.sv
// Streaming handshake bundle observed by io_protocol_monitor.
interface io_protocol_monitor_if #(
    parameter int unsigned OUT_W = 8,
    parameter int unsigned NCH   = 2
);
    logic                   in_valid;
    logic                   out_valid;
    logic [NCH*OUT_W-1:0]   out_data;

    modport master (output in_valid, output out_valid, output out_data);
    modport slave  (input  in_valid, input  out_valid, input  out_data);
endinterface

// File: rtl/io_protocol_monitor_sat_counter.sv
// Saturating up-counter; clr restarts the count and a coincident inc
// counts the first event, so a restart can load 1 directly.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count register: restart on clr, otherwise increment until all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/io_protocol_monitor.sv
// Protocol checker for the in_valid/out_valid streaming handshake: checks
// burst lengths, overlap, idle-zero outputs and latency, and keeps stats.
module io_protocol_monitor
    import io_mon_pkg::*;
#(
    parameter int unsigned OUT_W       = 8,
    parameter int unsigned NCH         = 2,
    parameter int unsigned IN_LEN      = 4,
    parameter int unsigned OUT_NUM     = 3,
    parameter int unsigned MAX_LATENCY = 100,
    parameter int unsigned TOT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    io_protocol_monitor_if.slave bus,
    output logic                 pat_done,
    output logic [15:0]          pat_cnt,
    output logic [15:0]          last_latency,
    output logic [TOT_W-1:0]     total_latency,
    output logic                 err,
    output logic [2:0]           err_code
);

    mon_state_t           state;
    err_code_t            viol;
    logic                 in_v;
    logic                 out_v;
    logic [NCH*OUT_W-1:0] data;
    logic [7:0]           in_cnt;
    logic [7:0]           out_cnt;
    logic [15:0]          lat_cnt;
    logic                 ok;
    logic                 done;
    logic                 in_clr, in_inc;
    logic                 out_clr, out_inc;
    logic                 lat_clr, lat_inc;

    assign in_v  = bus.in_valid;
    assign out_v = bus.out_valid;
    assign data  = bus.out_data;

    // Classify this cycle's sample; checks are ordered so the lowest code wins.
    // out_valid on the cycle in_valid drops is treated as spurious output.
    always_comb begin
        viol = ERR_NONE;
        if (state != ST_ERR) begin
            if (in_v && out_v) begin
                viol = ERR_OVERLAP;
            end else if (!out_v && (data != '0)) begin
                viol = ERR_NONZERO;
            end else begin
                case (state)
                    ST_IDLE: if (out_v) viol = ERR_SPURIOUS;
                    ST_IN: begin
                        if (in_v) begin
                            if (in_cnt == 8'(IN_LEN)) viol = ERR_IN_LEN;
                        end else if (in_cnt != 8'(IN_LEN)) begin
                            viol = ERR_IN_LEN;
                        end else if (out_v) begin
                            viol = ERR_SPURIOUS;
                        end
                    end
                    ST_WAIT: begin
                        if (!out_v && (lat_cnt == 16'(MAX_LATENCY - 1))) viol = ERR_LATENCY;
                        else if (in_v) viol = ERR_IN_LEN;
                    end
                    ST_OUT: begin
                        if (out_v) begin
                            if (out_cnt == 8'(OUT_NUM)) viol = ERR_OUT_CNT;
                        end else if (out_cnt != 8'(OUT_NUM)) begin
                            viol = ERR_OUT_CNT;
                        end
                    end
                    default: viol = ERR_NONE;
                endcase
            end
        end
    end

    // Counter controls: nothing moves on a violating cycle or once in ERR.
    always_comb begin
        ok      = (state != ST_ERR) && (viol == ERR_NONE);
        in_clr  = ok && (state == ST_IDLE) && in_v;
        in_inc  = ok && in_v && ((state == ST_IDLE) || (state == ST_IN));
        lat_clr = ok && (state == ST_IN) && !in_v;
        lat_inc = ok && (state == ST_WAIT) && !out_v;
        out_clr = ok && (state == ST_WAIT) && out_v;
        out_inc = ok && out_v && ((state == ST_WAIT) || (state == ST_OUT));
        done    = ok && (state == ST_OUT) && !out_v;
    end

    sat_counter #(.W(8))  u_in_cnt  (.clk(clk), .rst(rst), .clr(in_clr),  .inc(in_inc),  .cnt(in_cnt));
    sat_counter #(.W(8))  u_out_cnt (.clk(clk), .rst(rst), .clr(out_clr), .inc(out_inc), .cnt(out_cnt));
    sat_counter #(.W(16)) u_lat_cnt (.clk(clk), .rst(rst), .clr(lat_clr), .inc(lat_inc), .cnt(lat_cnt));
    sat_counter #(.W(16)) u_pat_cnt (.clk(clk), .rst(rst), .clr(1'b0),    .inc(done),    .cnt(pat_cnt));

    // Pattern FSM with registered status outputs; ERR is left only via rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            pat_done      <= 1'b0;
            last_latency  <= '0;
            total_latency <= '0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
        end else begin
            pat_done <= 1'b0;
            if (state != ST_ERR) begin
                if (viol != ERR_NONE) begin
                    state    <= ST_ERR;
                    err      <= 1'b1;
                    err_code <= viol;
                end else begin
                    case (state)
                        ST_IDLE: if (in_v)  state <= ST_IN;
                        ST_IN:   if (!in_v) state <= ST_WAIT;
                        ST_WAIT: if (out_v) state <= ST_OUT;
                        ST_OUT: begin
                            if (!out_v) begin
                                state         <= ST_IDLE;
                                pat_done      <= 1'b1;
                                last_latency  <= lat_cnt;
                                total_latency <= TOT_W'(sat_add(64'(total_latency), 64'(lat_cnt), TOT_W));
                            end
                        end
                        default: state <= ST_ERR;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_io_protocol_monitor.sv
// Directed bench for io_protocol_monitor with a pattern-level expectation model.
module tb_io_protocol_monitor;

    localparam int OUT_W       = 8;
    localparam int NCH         = 2;
    localparam int IN_LEN      = 4;
    localparam int OUT_NUM     = 3;
    localparam int MAX_LATENCY = 100;
    localparam int TOT_W       = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_protocol_monitor_if #(.OUT_W(OUT_W), .NCH(NCH)) bus ();

    logic             pat_done;
    logic [15:0]      pat_cnt;
    logic [15:0]      last_latency;
    logic [TOT_W-1:0] total_latency;
    logic             err;
    logic [2:0]       err_code;

    io_protocol_monitor #(
        .OUT_W(OUT_W), .NCH(NCH), .IN_LEN(IN_LEN), .OUT_NUM(OUT_NUM),
        .MAX_LATENCY(MAX_LATENCY), .TOT_W(TOT_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .pat_done(pat_done), .pat_cnt(pat_cnt), .last_latency(last_latency),
        .total_latency(total_latency), .err(err), .err_code(err_code)
    );

    int     n_vec  = 0;
    int     n_miss = 0;
    bit     chk_en = 1'b0;

    // Expected outputs, updated from what each pattern intends.
    bit     e_done;
    int     e_cnt;
    int     e_last;
    longint e_total;
    bit     e_err;
    int     e_code;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pat_done",      64'(pat_done),      64'(e_done));
            chk("pat_cnt",       64'(pat_cnt),       64'(e_cnt));
            chk("last_latency",  64'(last_latency),  64'(e_last));
            chk("total_latency", 64'(total_latency), 64'(e_total));
            chk("err",           64'(err),           64'(e_err));
            chk("err_code",      64'(err_code),      64'(e_code));
        end
    end

    task automatic model_clear();
        e_done = 0; e_cnt = 0; e_last = 0; e_total = 0; e_err = 0; e_code = 0;
    endtask

    task automatic flag(input int code);
        if (!e_err) begin
            e_err  = 1;
            e_code = code;
        end
    endtask

    task automatic complete(input int lat);
        e_done = 1;
        if (e_cnt < 65535) e_cnt++;
        e_last  = lat;
        e_total = e_total + lat;
    endtask

    // One sampled cycle; returns just after the sampling edge.
    task automatic step(input bit iv, input bit ov, input logic [15:0] d);
        bus.in_valid  = iv;
        bus.out_valid = ov;
        bus.out_data  = d;
        @(posedge clk);
        #1;
        e_done = 0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_pat_cnt",  64'(pat_cnt),       64'd0);
        chk("rst_err",      64'(err),           64'd0);
        chk("rst_total",    64'(total_latency), 64'd0);
    endtask

    // n_in input beats, lat idle cycles after the drop cycle, n_out output beats.
    task automatic pattern(input int n_in, input int lat, input int n_out, input bit zero_data);
        logic [15:0] d;
        for (int i = 0; i < n_in; i++) begin
            step(1, 0, '0);
            if (i == IN_LEN) flag(5);
        end
        step(0, 0, '0);
        if (n_in < IN_LEN) flag(5);
        for (int k = 0; k < lat; k++) begin
            step(0, 0, '0);
            if (k == MAX_LATENCY - 1) flag(3);
        end
        for (int j = 0; j < n_out; j++) begin
            d = zero_data ? 16'h0000 : 16'(16'h0101 * (j + 1));
            step(0, 1, d);
            if (j == OUT_NUM) flag(4);
        end
        step(0, 0, '0);
        if (n_out < OUT_NUM) flag(4);
        else if (!e_err) complete(lat);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        step(0, 0, '0);
        step(0, 0, '0);

        // Single legal pattern, latency 5.
        pattern(4, 5, 3, 0);
        chk("t1_done", 64'(pat_done),     64'd1);
        chk("t1_last", 64'(last_latency), 64'd5);
        chk("t1_cnt",  64'(pat_cnt),      64'd1);
        chk("t1_err",  64'(err),          64'd0);
        step(0, 0, '0);
        chk("t1_done_drop", 64'(pat_done), 64'd0);

        // Ten back-to-back patterns, latencies 0..9.
        do_reset();
        for (int k = 0; k < 10; k++) pattern(4, k, 3, k[0]);
        chk("t2_cnt",   64'(pat_cnt),       64'd10);
        chk("t2_total", 64'(total_latency), 64'd45);
        chk("t2_last",  64'(last_latency),  64'd9);
        chk("t2_err",   64'(err),           64'd0);

        // in_valid together with the first out_valid.
        do_reset();
        repeat (4) step(1, 0, '0);
        repeat (4) step(0, 0, '0);
        step(1, 1, 16'h0202);
        flag(1);
        chk("t3_err",  64'(err),      64'd1);
        chk("t3_code", 64'(err_code), 64'd1);
        step(0, 0, 16'h0100);
        step(0, 1, 16'h0303);
        pattern(4, 2, 3, 0);
        chk("t3_code_held", 64'(err_code), 64'd1);

        // Zero-data pattern is clean; channel 1 nonzero while idle is not.
        do_reset();
        pattern(4, 3, 3, 1);
        chk("t4_cnt", 64'(pat_cnt), 64'd1);
        step(0, 0, 16'h0100);
        flag(2);
        chk("t4_code", 64'(err_code), 64'd2);

        // Largest legal latency, then one cycle too many.
        do_reset();
        pattern(4, MAX_LATENCY - 1, 3, 0);
        chk("t5_last", 64'(last_latency), 64'd99);
        do_reset();
        pattern(4, MAX_LATENCY, 0, 0);
        chk("t5_code", 64'(err_code), 64'd3);

        // Wrong output beat counts.
        do_reset();
        pattern(4, 1, 2, 0);
        chk("t6_short", 64'(err_code), 64'd4);
        do_reset();
        pattern(4, 1, 4, 0);
        chk("t6_long", 64'(err_code), 64'd4);

        // Wrong input burst lengths.
        do_reset();
        pattern(3, 2, 3, 0);
        chk("t7_short", 64'(err_code), 64'd5);
        do_reset();
        pattern(5, 2, 3, 0);
        chk("t7_long", 64'(err_code), 64'd5);

        // Output with no preceding input.
        do_reset();
        step(0, 1, 16'h0404);
        flag(6);
        chk("t8_code", 64'(err_code), 64'd6);

        // Reset in the middle of WAIT, then a clean pattern.
        do_reset();
        repeat (4) step(1, 0, '0);
        repeat (4) step(0, 0, '0);
        do_reset();
        chk("t9_last", 64'(last_latency), 64'd0);
        chk("t9_code", 64'(err_code),     64'd0);
        pattern(4, 2, 3, 0);
        chk("t9_cnt", 64'(pat_cnt), 64'd1);
        step(0, 0, '0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
